// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the single-cycle datapath and the
// data-memory bus. Takes one memory instruction at a time, runs a
// handshaked bus access, and holds the PC while the access is in flight.
//
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   mem_rd, mem_wr       load / store request (both high -> store)
//   digit[2:0]           [1:0] size (00 word, 01 half, 10 byte, 11 word),
//                        [2] 1 = zero-extend load, 0 = sign-extend
//   addr, wdata          effective address, store data (rs2)
//   stall                hold PC and register-file write
//   misalign             misaligned access, no bus cycle issued
//   ld_data              extended load result, held until next load
//   bus_req/we/addr/be/wdata   registered bus request fields
//   bus_ready, bus_rdata slave handshake and read data
//   bus_err              timeout abort pulse (only with LSU_TIMEOUT_EN)
//
// Optional feature: define LSU_TIMEOUT_EN to abort a BUS access after
// TIMEOUT_CYCLES cycles without bus_ready.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  digit,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        misalign,
  output logic [31:0] ld_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
`ifdef LSU_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_chk
    $error("lsu_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, ld_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic        zext_q, byte_q, half_q;

  // ---------------- request decode (IDLE side) ----------------
  logic        is_byte, is_half, is_word, any_req, mis_c, go;
  logic [3:0]  be_c;
  logic [31:0] wd_c;

  always_comb begin
    is_byte = (digit[1:0] == 2'b10);
    is_half = (digit[1:0] == 2'b01);
    is_word = ~is_byte & ~is_half;
    any_req = mem_rd | mem_wr;
    mis_c   = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);
    go      = any_req & ~mis_c;

    be_c = 4'b1111;
    wd_c = wdata;
    if (is_byte) begin
      be_c = 4'b0001 << addr[1:0];
      wd_c = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_c = addr[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{wdata[15:0]}};
    end
  end

  assign misalign = (state_q == S_IDLE) & any_req & mis_c;
  assign stall    = ((state_q == S_IDLE) & go) | (state_q == S_BUS);

  // ---------------- load extraction (uses latched lane info) ----------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    if (byte_q)
      ld_ext = {{24{~zext_q & rd_byte[7]}}, rd_byte};
    else if (half_q)
      ld_ext = {{16{~zext_q & rd_half[15]}}, rd_half};
    else
      ld_ext = bus_rdata;
  end

  // ---------------- timeout (optional) ----------------
  logic abort;
`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  // The counter value seen in a BUS cycle is the number of earlier BUS
  // cycles without bus_ready; hitting TO_LAST here means this cycle makes
  // it reach TIMEOUT_CYCLES. A simultaneous bus_ready takes priority.
  assign abort = (state_q == S_BUS) & ~bus_ready & (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_BUS)
      cnt_d = 8'd0;
    else if (~bus_ready)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort;
    end
  end

  assign bus_err = err_q;
`else
  assign abort = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_BUS;
      S_BUS:   if (bus_ready | abort) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      zext_q  <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      ld_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      // bus_req is high exactly while the next state is BUS
      req_q   <= (state_d == S_BUS);
      if (state_q == S_IDLE && go) begin
        we_q    <= mem_wr;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wd_c;
        off_q   <= addr[1:0];
        zext_q  <= digit[2];
        byte_q  <= is_byte;
        half_q  <= is_half;
      end
      if (state_q == S_BUS && !we_q) begin
        if (bus_ready)
          ld_q <= ld_ext;
        else if (abort)
          ld_q <= 32'd0;
      end
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  digit = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, misalign, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
`ifdef LSU_TIMEOUT_EN
  logic        bus_err;
`endif

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .mem_rd(mem_rd), .mem_wr(mem_wr), .digit(digit),
    .addr(addr), .wdata(wdata), .stall(stall), .misalign(misalign),
    .ld_data(ld_data), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
`ifdef LSU_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_ld = 32'd0;

  // One memory instruction: IDLE cycle, (waits+1) BUS cycles, DONE cycle.
  // Expected bus fields and load result go into the scoreboard up front and
  // are checked as the DUT presents them.
  task automatic mem_op(input logic rd, input logic wr, input logic [2:0] dg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic [31:0] e_ld, input string nm);
    exp_t e, cur;
    int   nst;
    e.we = wr; e.addr = {a[31:2], 2'b00}; e.be = e_be; e.wd = e_wd;
    e.ld = wr ? last_ld : e_ld;
    exp_q.push_back(e);
    nst = 0;

    @(negedge clk);
    mem_rd = rd; mem_wr = wr; digit = dg; addr = a; wdata = wd;
    bus_ready = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1 || misalign !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: stall=%b misalign=%b req=%b, need 1 0 0", nm, stall, misalign, bus_req);
    end
    if (stall === 1'b1) nst++;

    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      cur = exp_q[0];
      n_cmp++;
      if (bus_req !== 1'b1 || stall !== 1'b1 || bus_we !== cur.we ||
          bus_addr !== cur.addr || bus_be !== cur.be || bus_wdata !== cur.wd) begin
        n_err++;
        $display("FAIL %s bus[%0d]: req=%b stall=%b we=%b addr=%h be=%b wd=%h, need 1 1 %b %h %b %h",
                 nm, i, bus_req, stall, bus_we, bus_addr, bus_be, bus_wdata,
                 cur.we, cur.addr, cur.be, cur.wd);
      end
      if (stall === 1'b1) nst++;
      if (i == waits) begin
        bus_ready = 1'b1;
        bus_rdata = rdat;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
    end

    @(negedge clk);
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    cur = exp_q.pop_front();
    n_cmp++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || ld_data !== cur.ld) begin
      n_err++;
      $display("FAIL %s done: stall=%b req=%b ld=%h, need 0 0 %h", nm, stall, bus_req, ld_data, cur.ld);
    end
`ifdef LSU_TIMEOUT_EN
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s bus_err: got %b need 0", nm, bus_err);
    end
`endif
    n_cmp++;
    if (nst != waits + 2) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d need %0d", nm, nst, waits + 2);
    end
    last_ld = cur.ld;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'd0 || bus_addr !== 32'd0 ||
        bus_wdata !== 32'd0 || ld_data !== 32'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset: req=%b we=%b be=%b addr=%h wd=%h ld=%h stall=%b, need all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, stall);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    mem_rd = 0; mem_wr = 0; addr = 32'h0000_0103; digit = 3'b000;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL nonmem: stall=%b misalign=%b need 0 0", stall, misalign);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL nonmem_req: got %b need 0", bus_req);
    end
  endtask

  task automatic test_misalign(input logic [2:0] dg, input logic [31:0] a, input string nm);
    @(negedge clk);
    mem_rd = 1; mem_wr = 0; digit = dg; addr = a;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0 || ld_data !== last_ld) begin
        n_err++;
        $display("FAIL %s[%0d]: mis=%b stall=%b req=%b ld=%h, need 1 0 0 %h",
                 nm, i, misalign, stall, bus_req, ld_data, last_ld);
      end
      @(negedge clk);
    end
    mem_rd = 0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    mem_rd = 1; mem_wr = 0; digit = 3'b000; addr = 32'h400; bus_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_bus: req=%b need 1", bus_req);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || ld_data !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_async: req=%b ld=%h need 0 0", bus_req, ld_data);
    end
    @(negedge clk);
    rstn = 1'b1; mem_rd = 0;
    last_ld = 32'd0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || ld_data !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_idle: req=%b stall=%b ld=%h need 0 0 0", bus_req, stall, ld_data);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    mem_rd = 1; mem_wr = 0; digit = 3'b000; addr = 32'h300; bus_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_req !== 1'b1 || bus_err !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_bus[%0d]: req=%b err=%b need 1 0", i, bus_req, bus_err);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b1 || bus_req !== 1'b0 || ld_data !== 32'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_done: err=%b req=%b ld=%h stall=%b need 1 0 0 0",
               bus_err, bus_req, ld_data, stall);
    end
    mem_rd = 0;
    last_ld = 32'd0;
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse: err=%b need 0", bus_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    // word store
    mem_op(0, 1, 3'b000, 32'h104, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, "sw");
    // lb / lbu
    mem_op(1, 0, 3'b010, 32'h203, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'hFFFFFF80, "lb");
    mem_op(1, 0, 3'b110, 32'h203, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'h00000080, "lbu");
    // lh with 3 wait cycles (also the timeout tie case when enabled)
    mem_op(1, 0, 3'b001, 32'h202, 32'h0, 32'h9ABC0000, 3, 4'b1100, 32'h0, 32'hFFFF9ABC, "lh");
    // byte/half stores, rd+wr together treated as store
    mem_op(0, 1, 3'b010, 32'h102, 32'h000000A5, 32'h0, 0, 4'b0100, 32'hA5A5A5A5, 32'h0, "sb");
    mem_op(1, 1, 3'b001, 32'h106, 32'h00001234, 32'h0, 2, 4'b1100, 32'h12341234, 32'h0, "sh_rdwr");
    test_misalign(3'b000, 32'h101, "mis_lw");
    test_misalign(3'b001, 32'h103, "mis_lh");
    // back-to-back loads: lhu low half, lbu byte 1, lw
    mem_op(1, 0, 3'b101, 32'h500, 32'h0, 32'h1234_F00D, 0, 4'b0011, 32'h0, 32'h0000F00D, "lhu");
    mem_op(1, 0, 3'b010, 32'h501, 32'h0, 32'h1234_7F0D, 0, 4'b0010, 32'h0, 32'h0000007F, "lb_pos");
    mem_op(1, 0, 3'b011, 32'h504, 32'h0, 32'hCAFEBABE, 0, 4'b1111, 32'h0, 32'hCAFEBABE, "lw11");
    test_rst_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    mem_op(1, 0, 3'b000, 32'h600, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h0, 32'h0BADF00D, "lw_after");
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
